// File: rtl/adc128s_fc_pkg.sv
// Shared constants and types for the ADC128S-style SPI converter model.
// Frame geometry, default channel map and sample type.
package adc128s_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CHNL_MSB   = 13;
  localparam int CHNL_LSB   = 11;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  typedef logic [11:0] adc_val_t;
  typedef logic [2:0]  chnl_t;

  localparam chnl_t CH_LD_LFT_DEF  = 3'd0;
  localparam chnl_t CH_LD_RGHT_DEF = 3'd4;
  localparam chnl_t CH_STEER_DEF   = 3'd5;
  localparam chnl_t CH_BATT_DEF    = 3'd6;

endpackage

// File: rtl/adc128s_fc_if.sv
// SPI bus between the serial master and the converter model.
// master drives select/clock/data, slave returns MISO.
interface adc128s_fc_if;

  logic SS_n;
  logic SCLK;
  logic MOSI;
  logic MISO;

  modport master (
    output SS_n,
    output SCLK,
    output MOSI,
    input  MISO
  );

  modport slave (
    input  SS_n,
    input  SCLK,
    input  MOSI,
    output MISO
  );

endinterface

// File: rtl/adc_spi_sync.sv
// Brings the asynchronous SPI pins into the clk domain.
// Two flops per pin, a third on SS_n/SCLK for edge pulses.
module adc_spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic ss_n_in,
  input  logic sclk_in,
  input  logic mosi_in,
  output logic ss_n_s,
  output logic mosi_s,
  output logic ss_fall,
  output logic ss_rise,
  output logic sclk_rise,
  output logic sclk_fall
);

  logic [2:0] ss_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  // shift pins through the synchroniser chain, idle levels on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_q   <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      ss_q   <= {ss_q[1:0], ss_n_in};
      sclk_q <= {sclk_q[1:0], sclk_in};
      mosi_q <= {mosi_q[0], mosi_in};
    end
  end

  assign ss_n_s    = ss_q[1];
  assign mosi_s    = mosi_q[1];
  assign ss_fall   = ss_q[2] & ~ss_q[1];
  assign ss_rise   = ~ss_q[2] & ss_q[1];
  assign sclk_rise = ~sclk_q[2] & sclk_q[1];
  assign sclk_fall = sclk_q[2] & ~sclk_q[1];

endmodule

// File: rtl/adc128s_fc.sv
// Behavioural 12-bit 8-channel pipelined SPI ADC for the Segway bench.
// Optional macro ADC_MISO_TRISTATE_EN: MISO floats when idle/reset.
module adc128s_fc
  import adc128s_pkg::*;
#(
  parameter chnl_t CH_LD_LFT  = CH_LD_LFT_DEF,
  parameter chnl_t CH_LD_RGHT = CH_LD_RGHT_DEF,
  parameter chnl_t CH_STEER   = CH_STEER_DEF,
  parameter chnl_t CH_BATT    = CH_BATT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  adc128s_fc_if.slave     spi,
  input  adc_val_t        ld_cell_lft,
  input  adc_val_t        ld_cell_rght,
  input  adc_val_t        steerPot,
  input  adc_val_t        batt
);

  logic ss_n_s;
  logic mosi_s;
  logic ss_fall;
  logic ss_rise;
  logic sclk_rise;
  logic sclk_fall;

  logic [FRAME_BITS-1:0] tx_shft;
  // bit 15 of the received word is never observed, so it is not kept
  logic [FRAME_BITS-2:0] rx_shft;
  logic [CNT_W-1:0]      bit_cnt;
  chnl_t                 chnl;
  adc_val_t              sel_val;

  adc_spi_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .ss_n_in   (spi.SS_n),
    .sclk_in   (spi.SCLK),
    .mosi_in   (spi.MOSI),
    .ss_n_s    (ss_n_s),
    .mosi_s    (mosi_s),
    .ss_fall   (ss_fall),
    .ss_rise   (ss_rise),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall)
  );

  // analog value of the channel addressed by the previous frame
  always_comb begin
    sel_val = '0;
    priority case (1'b1)
      (chnl == CH_LD_LFT):  sel_val = ld_cell_lft;
      (chnl == CH_LD_RGHT): sel_val = ld_cell_rght;
      (chnl == CH_STEER):   sel_val = steerPot;
      (chnl == CH_BATT):    sel_val = batt;
      default:              sel_val = '0;
    endcase
  end

  // frame engine: snapshot on select, shift on SCLK, latch channel on release
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shft <= '0;
      rx_shft <= '0;
      bit_cnt <= '0;
      chnl    <= 3'd0;
    end else if (ss_fall) begin
      tx_shft <= {4'h0, sel_val};
      rx_shft <= '0;
      bit_cnt <= '0;
    end else if (ss_rise) begin
      if (bit_cnt == CNT_W'(FRAME_BITS))
        chnl <= rx_shft[CHNL_MSB:CHNL_LSB];
    end else if (!ss_n_s) begin
      if (sclk_rise) begin
        rx_shft <= {rx_shft[FRAME_BITS-3:0], mosi_s};
        if (bit_cnt != CNT_W'(FRAME_BITS))
          bit_cnt <= bit_cnt + 1'b1;
      end
      if (sclk_fall)
        tx_shft <= {tx_shft[FRAME_BITS-2:0], 1'b0};
    end
  end

`ifdef ADC_MISO_TRISTATE_EN
  assign spi.MISO = (rst || ss_n_s) ? 1'bz : tx_shft[FRAME_BITS-1];
`else
  assign spi.MISO = (rst || ss_n_s) ? 1'b0 : tx_shft[FRAME_BITS-1];
`endif

endmodule

// File: tb/tb_adc128s_fc.sv
// Directed bench for adc128s_fc: pipelined channel reads, abort,
// over-long frame, mid-frame snapshot and reset, MISO idle level.
module tb_adc128s_fc;
  import adc128s_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  adc_val_t ld_cell_lft  = 12'h300;
  adc_val_t ld_cell_rght = 12'h2A5;
  adc_val_t steerPot     = 12'h000;
  adc_val_t batt         = 12'hC00;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] got;
  logic        miso_idle;

  adc128s_fc_if spi ();

  adc128s_fc u_dut (
    .clk          (clk),
    .rst          (rst),
    .spi          (spi.slave),
    .ld_cell_lft  (ld_cell_lft),
    .ld_cell_rght (ld_cell_rght),
    .steerPot     (steerPot),
    .batt         (batt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // one SPI transaction, MSB first, SCLK phases of 5 clk;
  // optionally changes ld_cell_lft just before bit chg_bit
  task automatic frame(input logic [31:0] cmd, input int nbits,
                       input int chg_bit, input adc_val_t chg_val,
                       output logic [31:0] rd);
    rd = '0;
    spi.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      if (k == chg_bit) ld_cell_lft = chg_val;
      spi.MOSI = cmd[nbits-1-k];
      repeat (5) @(negedge clk);
      rd = {rd[30:0], spi.MISO};
      spi.SCLK = 1'b1;
      repeat (5) @(negedge clk);
      spi.SCLK = 1'b0;
    end
    repeat (5) @(negedge clk);
    spi.SS_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
`ifdef ADC_MISO_TRISTATE_EN
    miso_idle = 1'bz;
`else
    miso_idle = 1'b0;
`endif
    spi.SS_n = 1'b1;
    spi.SCLK = 1'b0;
    spi.MOSI = 1'b0;
    repeat (4) @(negedge clk);
    check("miso_in_reset", {31'b0, spi.MISO}, {31'b0, miso_idle});
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("miso_idle", {31'b0, spi.MISO}, {31'b0, miso_idle});

    frame(32'h0000, 16, -1, '0, got);
    check("ch0_default", got, 32'h0300);
    frame(32'h2000, 16, -1, '0, got);
    check("ch0_again", got, 32'h0300);
    frame(32'h3000, 16, -1, '0, got);
    check("ch4_rght", got, 32'h02A5);
    frame(32'h3000, 16, -1, '0, got);
    check("ch6_batt", got, 32'h0C00);
    batt = 12'h3A0;
    frame(32'h0800, 16, -1, '0, got);
    check("ch6_batt_new", got, 32'h03A0);
    frame(32'h2800, 16, -1, '0, got);
    check("ch1_unmapped", got, 32'h0000);
    steerPot = 12'h800;
    frame(32'h3000, 16, -1, '0, got);
    check("ch5_steer", got, 32'h0800);
    check("miso_between", {31'b0, spi.MISO}, {31'b0, miso_idle});

    frame(32'h0028, 8, -1, '0, got);
    check("abort_first8", got, 32'h03);
    frame(32'h0000, 16, -1, '0, got);
    check("after_abort", got, 32'h03A0);

    frame(32'h0000, 16, 4, 12'h555, got);
    check("snapshot", got, 32'h0300);

    frame(32'hF2000, 20, -1, '0, got);
    check("long_frame", got, 32'h05550);
    frame(32'h0000, 16, -1, '0, got);
    check("long_chnl", got, 32'h02A5);

    frame(32'hE7FF, 16, -1, '0, got);
    check("ign_bits_lft", got, 32'h0555);
    frame(32'h3000, 16, -1, '0, got);
    check("ign_bits_ch4", got, 32'h02A5);

    spi.SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      spi.MOSI = 1'b1;
      repeat (5) @(negedge clk);
      spi.SCLK = 1'b1;
      repeat (5) @(negedge clk);
      spi.SCLK = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("miso_rst_mid", {31'b0, spi.MISO}, {31'b0, miso_idle});
    spi.SS_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    frame(32'h0000, 16, -1, '0, got);
    check("after_rst", got, 32'h0555);
    check("miso_end", {31'b0, spi.MISO}, {31'b0, miso_idle});

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
